// File: rtl/n64_poll_sched_pkg.sv
// Shared types and constants for the N64 poll scheduler: FSM encoding, bus widths,
// default timing constants and a saturating-increment helper.
package n64_poll_sched_pkg;

  localparam int unsigned REPLY_W = 32;
  localparam int unsigned FAIL_W  = 8;
  localparam int unsigned TO_W    = 12;

  localparam int unsigned POLL_PERIOD_DEF = 2048;
  localparam int unsigned TX_START_TO_DEF = 16;
  localparam int unsigned RX_TO_DEF       = 800;
  localparam int unsigned MAX_FAIL_DEF    = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_TX   = 3'd2,
    ST_RX   = 3'd3,
    ST_DONE = 3'd4,
    ST_FAIL = 3'd5
  } state_t;

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v,
                                                input logic [FAIL_W-1:0] lim);
    sat_inc = (v >= lim) ? v : v + FAIL_W'(1);
  endfunction

endpackage

// File: rtl/n64_poll_sched_if.sv
// Signal bundle between the poll scheduler, the tx/rx read-command blocks and user logic.
interface n64_poll_sched_if;
  import n64_poll_sched_pkg::*;

  logic               enable;
  logic               poll_now;
  logic               tx_trigger;
  logic               tx_busy;
  logic               rx_enable;
  logic               rx_strobe;
  logic [REPLY_W-1:0] rx_data;
  logic [REPLY_W-1:0] ctrl_state;
  logic               state_valid;
  logic               ctrl_present;
  logic [FAIL_W-1:0]  fail_count;
  logic               busy;

  modport master (
    input  enable, poll_now, tx_busy, rx_strobe, rx_data,
    output tx_trigger, rx_enable, ctrl_state, state_valid, ctrl_present, fail_count, busy
  );

  modport slave (
    output enable, poll_now, tx_busy, rx_strobe, rx_data,
    input  tx_trigger, rx_enable, ctrl_state, state_valid, ctrl_present, fail_count, busy
  );

endinterface

// File: rtl/n64_poll_sched_timeout_ctr.sv
// Loadable down-counter shared by the SEND and RX phases; expired_c flags a zero count.
module n64_poll_sched_timeout_ctr
  import n64_poll_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [TO_W-1:0] load_val,
  output logic            expired_c
);

  logic [TO_W-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - TO_W'(1);
    end
  end

  assign expired_c = (value == '0);

endmodule

// File: rtl/n64_poll_sched.sv
// Poll sequencer for the N64 read-command datapath: triggers tx, gates rx, detects
// timeouts and publishes the last good controller state plus presence status.
module n64_poll_sched
  import n64_poll_sched_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = POLL_PERIOD_DEF,
  parameter int unsigned TX_START_TO = TX_START_TO_DEF,
  parameter int unsigned RX_TO       = RX_TO_DEF,
  parameter int unsigned MAX_FAIL    = MAX_FAIL_DEF
)(
  input  logic             clk_4M,
  input  logic             rst,
  n64_poll_sched_if.master bus
);

  localparam int unsigned      PER_W      = $clog2(POLL_PERIOD);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_PERIOD - 1);
  localparam logic [TO_W-1:0]  TX_LOAD    = TO_W'(TX_START_TO - 1);
  localparam logic [TO_W-1:0]  RX_LOAD    = TO_W'(RX_TO - 1);
  localparam logic [FAIL_W-1:0] FAIL_SAT   = FAIL_W'(255);
  localparam logic [FAIL_W-1:0] CONSEC_SAT = FAIL_W'(MAX_FAIL);

  state_t             state;
  state_t             nxt;
  logic [PER_W-1:0]   period_cnt;
  logic               pending;
  logic               strobe_q;
  logic [FAIL_W-1:0]  consec_fail;
  logic [FAIL_W-1:0]  consec_inc_c;
  logic               start_c;
  logic               fall_c;
  logic               to_load_c;
  logic               to_dec_c;
  logic               to_expired_c;
  logic [TO_W-1:0]    to_load_val_c;

  assign fall_c       = strobe_q & ~bus.rx_strobe;
  assign start_c      = (bus.enable && (period_cnt >= PER_LAST)) || pending || bus.poll_now;
  assign consec_inc_c = sat_inc(consec_fail, CONSEC_SAT);

  // A strobe edge beats a timeout expiring on the same cycle.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (start_c) nxt = ST_SEND;
      ST_SEND: begin
        if (bus.tx_busy)       nxt = ST_TX;
        else if (to_expired_c) nxt = ST_FAIL;
      end
      ST_TX:   if (!bus.tx_busy) nxt = ST_RX;
      ST_RX: begin
        if (fall_c)            nxt = ST_DONE;
        else if (to_expired_c) nxt = ST_FAIL;
      end
      ST_DONE: nxt = ST_IDLE;
      ST_FAIL: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // One counter serves both waits; reloaded whenever SEND or RX is entered.
  assign to_load_c     = (nxt != state) && ((nxt == ST_SEND) || (nxt == ST_RX));
  assign to_load_val_c = (nxt == ST_SEND) ? TX_LOAD : RX_LOAD;
  assign to_dec_c      = (state == ST_SEND) || (state == ST_RX);

  n64_poll_sched_timeout_ctr u_timeout (
    .clk       (clk_4M),
    .rst       (rst),
    .load      (to_load_c),
    .dec       (to_dec_c),
    .load_val  (to_load_val_c),
    .expired_c (to_expired_c)
  );

  // State plus outputs registered from the next state so they align with it.
  always_ff @(posedge clk_4M or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      period_cnt       <= '0;
      pending          <= 1'b0;
      strobe_q         <= 1'b0;
      consec_fail      <= '0;
      bus.tx_trigger   <= 1'b0;
      bus.rx_enable    <= 1'b0;
      bus.ctrl_state   <= '0;
      bus.state_valid  <= 1'b0;
      bus.ctrl_present <= 1'b0;
      bus.fail_count   <= '0;
      bus.busy         <= 1'b0;
    end else begin
      state           <= nxt;
      strobe_q        <= bus.rx_strobe;
      bus.tx_trigger  <= (nxt == ST_SEND);
      bus.rx_enable   <= (nxt == ST_RX);
      bus.busy        <= (nxt != ST_IDLE);
      bus.state_valid <= (nxt == ST_DONE);

      if ((state == ST_IDLE) && start_c) begin
        period_cnt <= '0;
        pending    <= 1'b0;
      end else begin
        if (period_cnt < PER_LAST) period_cnt <= period_cnt + PER_W'(1);
        pending <= pending | bus.poll_now;
      end

      if (nxt == ST_DONE) begin
        bus.ctrl_state   <= bus.rx_data;
        bus.ctrl_present <= 1'b1;
        consec_fail      <= '0;
      end

      if (nxt == ST_FAIL) begin
        bus.fail_count <= sat_inc(bus.fail_count, FAIL_SAT);
        consec_fail    <= consec_inc_c;
        if (consec_inc_c >= CONSEC_SAT) begin
          bus.ctrl_present <= 1'b0;
          bus.ctrl_state   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_n64_poll_sched.sv
// Directed bench for n64_poll_sched: periodic polls, timeouts, request merging, reset.
module tb_n64_poll_sched;
  import n64_poll_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  n64_poll_sched_if bif ();

  n64_poll_sched dut (
    .clk_4M (clk),
    .rst    (rst),
    .bus    (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trigger(input int limit, output int n);
    n = 0;
    while (!bif.tx_trigger && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Called just after tx_trigger is seen high; returns just after RX is entered.
  task automatic serve_tx();
    repeat (8) tick();
    bif.tx_busy = 1'b1;
    repeat (96) tick();
    bif.tx_busy = 1'b0;
    tick();
  endtask

  task automatic pulse_poll_now();
    bif.poll_now = 1'b1;
    tick();
    bif.poll_now = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.enable = 1'b0; bif.poll_now = 1'b0; bif.tx_busy = 1'b0;
    bif.rx_strobe = 1'b1; bif.rx_data = '0;
    repeat (3) tick();
    checks++;
    if ({bif.tx_trigger, bif.rx_enable, bif.state_valid, bif.ctrl_present, bif.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bif.tx_trigger, bif.rx_enable, bif.state_valid, bif.ctrl_present, bif.busy});
    end
    checks++;
    if ({bif.ctrl_state, bif.fail_count} !== 40'h0) begin
      errors++;
      $display("FAIL reset_state: got %h/%0d expected 0/0", bif.ctrl_state, bif.fail_count);
    end
  endtask

  task automatic test_normal_poll();
    int n;
    int t1;
    bif.enable = 1'b1;
    rst = 1'b0;
    wait_trigger(2100, n);
    checks++;
    if (n !== 2048) begin errors++; $display("FAIL first_poll_delay: got %0d expected 2048", n); end
    t1 = cyc;
    checks++;
    if ({bif.busy, bif.rx_enable} !== 2'b10) begin
      errors++; $display("FAIL send_flags: got busy,rx_en=%b expected 10", {bif.busy, bif.rx_enable});
    end
    serve_tx();
    checks++;
    if ({bif.rx_enable, bif.tx_trigger} !== 2'b10) begin
      errors++; $display("FAIL rx_flags: got rx_en,trig=%b expected 10", {bif.rx_enable, bif.tx_trigger});
    end
    repeat (528) tick();
    bif.rx_data = 32'h8000_0000;
    bif.rx_strobe = 1'b0;
    tick();
    checks++;
    if (bif.state_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %0b expected 1", bif.state_valid); end
    checks++;
    if (bif.ctrl_state !== 32'h8000_0000) begin
      errors++; $display("FAIL normal_state: got %h expected 80000000", bif.ctrl_state);
    end
    checks++;
    if (bif.ctrl_present !== 1'b1) begin errors++; $display("FAIL normal_present: got %0b expected 1", bif.ctrl_present); end
    bif.rx_strobe = 1'b1;
    tick();
    checks++;
    if ({bif.state_valid, bif.busy, bif.rx_enable} !== 3'b000) begin
      errors++; $display("FAIL normal_after: got valid,busy,rx_en=%b expected 000",
                         {bif.state_valid, bif.busy, bif.rx_enable});
    end
    wait_trigger(2100, n);
    checks++;
    if (cyc - t1 !== 2048) begin errors++; $display("FAIL poll_period: got %0d expected 2048", cyc - t1); end
    serve_tx();
    repeat (528) tick();
    bif.rx_data = 32'h1234_5678;
    bif.rx_strobe = 1'b0;
    tick();
    checks++;
    if (bif.ctrl_state !== 32'h1234_5678) begin
      errors++; $display("FAIL second_state: got %h expected 12345678", bif.ctrl_state);
    end
    bif.rx_strobe = 1'b1;
    tick();
  endtask

  task automatic test_no_reply();
    int n;
    for (int i = 1; i <= 3; i++) begin
      wait_trigger(2100, n);
      checks++;
      if (n >= 2100) begin errors++; $display("FAIL noreply_trigger%0d: got none expected trigger", i); end
      serve_tx();
      n = 0;
      while (bif.rx_enable && n < 900) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 800) begin errors++; $display("FAIL rx_timeout%0d: got %0d cycles expected 800", i, n); end
      checks++;
      if (bif.fail_count !== 8'(i)) begin
        errors++; $display("FAIL noreply_count%0d: got %0d expected %0d", i, bif.fail_count, i);
      end
      checks++;
      if (bif.ctrl_present !== (i < 3) ||
          bif.ctrl_state !== ((i < 3) ? 32'h1234_5678 : 32'h0)) begin
        errors++; $display("FAIL noreply_status%0d: got present=%0b state=%h expected %0b/%h", i,
                           bif.ctrl_present, bif.ctrl_state, (i < 3), (i < 3) ? 32'h1234_5678 : 32'h0);
      end
    end
    wait_trigger(2100, n);
    serve_tx();
    repeat (528) tick();
    bif.rx_data = 32'h0000_00A5;
    bif.rx_strobe = 1'b0;
    tick();
    bif.enable = 1'b0;
    checks++;
    if ({bif.ctrl_present, bif.ctrl_state, bif.fail_count} !== {1'b1, 32'h0000_00A5, 8'd3}) begin
      errors++; $display("FAIL recover: got present=%0b state=%h count=%0d expected 1/000000a5/3",
                         bif.ctrl_present, bif.ctrl_state, bif.fail_count);
    end
    bif.rx_strobe = 1'b1;
    tick();
  endtask

  task automatic test_tx_stuck();
    int n;
    pulse_poll_now();
    n = 0;
    while (bif.tx_trigger && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL tx_stuck_hold: got %0d cycles expected 16", n); end
    checks++;
    if ({bif.fail_count, bif.ctrl_present} !== {8'd4, 1'b1}) begin
      errors++; $display("FAIL tx_stuck_count: got count=%0d present=%0b expected 4/1",
                         bif.fail_count, bif.ctrl_present);
    end
    tick();
  endtask

  task automatic test_poll_now_merge();
    int n;
    bif.rx_strobe = 1'b0;
    tick();
    bif.rx_strobe = 1'b1;
    tick();
    checks++;
    if ({bif.busy, bif.state_valid} !== 2'b00) begin
      errors++; $display("FAIL idle_strobe: got busy,valid=%b expected 00", {bif.busy, bif.state_valid});
    end
    pulse_poll_now();
    checks++;
    if (bif.tx_trigger !== 1'b1) begin errors++; $display("FAIL poll_now_start: got %0b expected 1", bif.tx_trigger); end
    serve_tx();
    tick();
    pulse_poll_now();
    tick();
    pulse_poll_now();
    repeat (100) tick();
    bif.rx_data = 32'h0F0F_F0F0;
    bif.rx_strobe = 1'b0;
    tick();
    checks++;
    if ({bif.state_valid, bif.ctrl_state} !== {1'b1, 32'h0F0F_F0F0}) begin
      errors++; $display("FAIL merge_reply: got valid=%0b state=%h expected 1/0f0ff0f0",
                         bif.state_valid, bif.ctrl_state);
    end
    bif.rx_strobe = 1'b1;
    tick();
    checks++;
    if ({bif.busy, bif.tx_trigger} !== 2'b00) begin
      errors++; $display("FAIL merge_idle: got busy,trig=%b expected 00", {bif.busy, bif.tx_trigger});
    end
    tick();
    checks++;
    if (bif.tx_trigger !== 1'b1) begin errors++; $display("FAIL pending_start: got %0b expected 1", bif.tx_trigger); end
    serve_tx();
    repeat (40) tick();
    bif.rx_data = 32'h0000_0001;
    bif.rx_strobe = 1'b0;
    tick();
    bif.rx_strobe = 1'b1;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bif.tx_trigger) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL extra_polls: got %0d trigger cycles expected 0", n); end
  endtask

  task automatic test_strobe_timeout_tie();
    pulse_poll_now();
    serve_tx();
    repeat (799) tick();
    bif.rx_data = 32'hDEAD_BEEF;
    bif.rx_strobe = 1'b0;
    tick();
    checks++;
    if ({bif.state_valid, bif.ctrl_state} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL tie_capture: got valid=%0b state=%h expected 1/deadbeef",
                         bif.state_valid, bif.ctrl_state);
    end
    checks++;
    if (bif.fail_count !== 8'd4) begin errors++; $display("FAIL tie_count: got %0d expected 4", bif.fail_count); end
    bif.rx_strobe = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_rx();
    int n;
    pulse_poll_now();
    serve_tx();
    repeat (10) tick();
    checks++;
    if (bif.rx_enable !== 1'b1) begin errors++; $display("FAIL pre_reset_rx: got %0b expected 1", bif.rx_enable); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bif.tx_trigger, bif.rx_enable, bif.state_valid, bif.ctrl_present, bif.busy,
         bif.ctrl_state, bif.fail_count} !== 45'h0) begin
      errors++; $display("FAIL async_reset: got rx_en=%0b present=%0b busy=%0b state=%h count=%0d expected all 0",
                         bif.rx_enable, bif.ctrl_present, bif.busy, bif.ctrl_state, bif.fail_count);
    end
    tick();
    tick();
    bif.enable = 1'b1;
    rst = 1'b0;
    wait_trigger(2100, n);
    checks++;
    if (n !== 2048) begin errors++; $display("FAIL post_reset_delay: got %0d expected 2048", n); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal_poll();
    test_no_reply();
    test_tx_stuck();
    test_poll_now_merge();
    test_strobe_timeout_tie();
    test_reset_mid_rx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
